uart_ram_loader: RTL and testbench

Byte-to-word loader between the RS-232 receiver and the 128x32 single-port RAM. Collects received UART bytes, packs each group of four into a 32-bit word (first byte in bits [31:24]), and writes the words to consecutive RAM addresses starting at 0. It asserts a one-cycle `done` after the last address is written. The loader drives the RAM port directly.

---
 rtl/uart_ram_loader.sv | 127 ++++++++++++
 tb/tb_uart_ram_loader.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_ram_loader.sv
// Packs received UART bytes into 32-bit words (first byte in [31:24]) and
// writes them to consecutive RAM addresses 0..LAST_ADDR, then pulses done.
module uart_ram_loader #(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned LAST_ADDR  = 127
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic                  start,
  output logic                  ram_en,
  output logic                  ram_action,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_wdata,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  overflow
);

  localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic [31:0]           shreg_q, shreg_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [31:0]           wdata_d;
  logic [CNT_WIDTH-1:0]  cnt_d;
  logic                  ovf_d;
  logic                  last_addr;

  assign last_addr = (ram_addr == ADDR_WIDTH'(LAST_ADDR));

  // State register plus all registered outputs, derived from next-state values
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= 2'd0;
      shreg_q    <= 32'd0;
      ram_addr   <= '0;
      ram_wdata  <= 32'd0;
      word_count <= '0;
      overflow   <= 1'b0;
      ram_en     <= 1'b0;
      ram_action <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      shreg_q    <= shreg_d;
      ram_addr   <= addr_d;
      ram_wdata  <= wdata_d;
      word_count <= cnt_d;
      overflow   <= ovf_d;
      ram_en     <= (state_d == WRITE);
      ram_action <= (state_d == WRITE);
      busy       <= (state_d == COLLECT) || (state_d == WRITE);
      done       <= (state_d == DONE);
    end
  end

  // Next-state and datapath; start overrides everything, including a pending byte
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    addr_d  = ram_addr;
    wdata_d = ram_wdata;
    cnt_d   = word_count;
    ovf_d   = overflow;

    if (start) begin
      state_d = COLLECT;
      idx_d   = 2'd0;
      shreg_d = 32'd0;
      addr_d  = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rx_valid) ovf_d = 1'b1;
        end
        COLLECT: begin
          if (rx_valid) begin
            shreg_d = {shreg_q[23:0], rx_data};
            idx_d   = 2'(idx_q + 2'd1);
            if (idx_q == 2'd3) begin
              wdata_d = {shreg_q[23:0], rx_data};
              state_d = WRITE;
            end
          end
        end
        WRITE: begin
          cnt_d = CNT_WIDTH'(word_count + 1'b1);
          if (last_addr) begin
            state_d = DONE;
            // Nothing left to load, so a byte here has nowhere to go
            if (rx_valid) ovf_d = 1'b1;
          end else begin
            addr_d  = ADDR_WIDTH'(ram_addr + 1'b1);
            state_d = COLLECT;
            if (rx_valid) begin
              shreg_d = {shreg_q[23:0], rx_data};
              idx_d   = 2'(idx_q + 2'd1);
            end
          end
        end
        DONE: begin
          state_d = IDLE;
          if (rx_valid) ovf_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_ram_loader.sv
// Directed self-checking bench for uart_ram_loader with a behavioural RAM.
module tb_uart_ram_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        start;
  logic        ram_en;
  logic        ram_action;
  logic [6:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic        busy;
  logic        done;
  logic [7:0]  word_count;
  logic        overflow;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int wr_count = 0;
  int done_count = 0;
  int wr_base;
  logic [31:0] mem [128];
  logic [31:0] exp_word;

  uart_ram_loader #(.ADDR_WIDTH(7), .LAST_ADDR(127)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .start      (start),
    .ram_en     (ram_en),
    .ram_action (ram_action),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .busy       (busy),
    .done       (done),
    .word_count (word_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // RAM model: captures at the end of any cycle with en and action high
  always @(posedge clk) begin
    if (ram_en && ram_action) begin
      mem[ram_addr] <= ram_wdata;
      wr_count      <= wr_count + 1;
    end
    if (done) done_count <= done_count + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'd0;
    for (int k = 0; k < 128; k++) mem[k] = 32'hDEAD_BEEF;

    // Reset with random byte traffic
    for (int i = 0; i < 2; i++) begin
      rx_valid = 1'($urandom_range(1, 0));
      rx_data  = 8'($urandom);
      tick();
    end
    check("rst_ram_en", 32'(ram_en), 32'd0);
    check("rst_ram_action", 32'(ram_action), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_wdata", ram_wdata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_no_write", 32'(wr_count), 32'd0);
    rx_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // Single word, bytes spaced 3 cycles apart
    pulse_start();
    check("sw_busy", 32'(busy), 32'd1);
    send(8'h11); check("sw_no_en_b0", 32'(ram_en), 32'd0); tick(); tick();
    send(8'h22); tick(); tick();
    send(8'h33); check("sw_no_en_b2", 32'(ram_en), 32'd0); tick(); tick();
    send(8'h44);
    check("sw_ram_en", 32'(ram_en), 32'd1);
    check("sw_ram_action", 32'(ram_action), 32'd1);
    check("sw_ram_addr", 32'(ram_addr), 32'd0);
    check("sw_ram_wdata", ram_wdata, 32'h1122_3344);
    tick();
    check("sw_word_count", 32'(word_count), 32'd1);
    check("sw_en_drop", 32'(ram_en), 32'd0);
    check("sw_writes", 32'(wr_count), 32'd1);
    check("sw_mem0", mem[0], 32'h1122_3344);

    // Back-to-back full load of 512 bytes
    pulse_start();
    wr_base = wr_count;
    for (int i = 0; i < 512; i++) send(8'(i));
    check("bb_last_en", 32'(ram_en), 32'd1);
    check("bb_last_addr", 32'(ram_addr), 32'd127);
    check("bb_done_early", 32'(done), 32'd0);
    tick();
    check("bb_done", 32'(done), 32'd1);
    check("bb_busy", 32'(busy), 32'd0);
    check("bb_word_count", 32'(word_count), 32'd128);
    check("bb_ram_addr", 32'(ram_addr), 32'd127);
    check("bb_overflow", 32'(overflow), 32'd0);
    check("bb_writes", 32'(wr_count - wr_base), 32'd128);
    for (int k = 0; k < 128; k++) begin
      exp_word = {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)};
      check($sformatf("bb_mem%0d", k), mem[k], exp_word);
    end
    tick();
    check("bb_done_once", 32'(done_count), 32'd1);
    check("bb_addr_hold", 32'(ram_addr), 32'd127);

    // Overflow after done
    wr_base = wr_count;
    send(8'hAA);
    check("ov_set", 32'(overflow), 32'd1);
    check("ov_no_en", 32'(ram_en), 32'd0);
    tick();
    check("ov_sticky", 32'(overflow), 32'd1);
    check("ov_no_write", 32'(wr_count - wr_base), 32'd0);
    pulse_start();
    check("ov_clear", 32'(overflow), 32'd0);
    check("ov_restart_count", 32'(word_count), 32'd0);
    check("ov_restart_addr", 32'(ram_addr), 32'd0);

    // Abort a partial word with a second start
    send(8'h01); send(8'h02);
    pulse_start();
    wr_base = wr_count;
    send(8'hA0); send(8'hA1); send(8'hA2); send(8'hA3);
    check("ab_en", 32'(ram_en), 32'd1);
    check("ab_addr", 32'(ram_addr), 32'd0);
    check("ab_wdata", ram_wdata, 32'hA0A1_A2A3);
    tick();
    check("ab_writes", 32'(wr_count - wr_base), 32'd1);
    check("ab_mem0", mem[0], 32'hA0A1_A2A3);
    check("ab_word_count", 32'(word_count), 32'd1);

    // Reset in the middle of a load with bytes still arriving
    pulse_start();
    wr_base = wr_count;
    for (int i = 0; i < 40; i++) send(8'(i + 7));
    check("rm_pre_en", 32'(ram_en), 32'd1);
    check("rm_pre_count", 32'(word_count), 32'd9);
    rst_n = 1'b0;
    send(8'h55);
    rst_n = 1'b1;
    check("rm_busy", 32'(busy), 32'd0);
    check("rm_word_count", 32'(word_count), 32'd0);
    check("rm_ram_en", 32'(ram_en), 32'd0);
    check("rm_ram_addr", 32'(ram_addr), 32'd0);
    check("rm_ram_wdata", ram_wdata, 32'd0);
    for (int i = 0; i < 8; i++) send(8'(i));
    check("rm_no_more_writes", 32'(wr_count - wr_base), 32'd10);
    check("rm_idle_busy", 32'(busy), 32'd0);
    check("rm_idle_overflow", 32'(overflow), 32'd1);

    // start with a simultaneous byte: byte dropped, overflow not set
    start = 1'b1;
    send(8'hEE);
    start = 1'b0;
    check("sv_overflow", 32'(overflow), 32'd0);
    check("sv_busy", 32'(busy), 32'd1);
    wr_base = wr_count;
    send(8'hC0); send(8'hC1); send(8'hC2); send(8'hC3);
    check("sv_wdata", ram_wdata, 32'hC0C1_C2C3);
    check("sv_addr", 32'(ram_addr), 32'd0);
    tick();
    check("sv_writes", 32'(wr_count - wr_base), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
